// File: rtl/satatrn_txarbiter.sv
// ---------------------------------------------------------------------------
// satatrn_txarbiter
//
// Transport-layer transmit arbiter. Shares the single link-layer transmit
// stream between a register/command FIS source (complete FIS, header
// included) and a data source (raw payload dwords only). For data the block
// prepends the DATA FIS header (type 8'h46) and splits long payloads into
// several DATA FIS of at most MAXDW payload dwords each.
//
// Optional feature macro: TXARB_FAIRNESS_EN
//   undefined : strict register priority when both sources request together
//   defined   : the source that lost the previous arbitration wins a tie
//
// Parameters
//   MAXDW    maximum payload dwords per DATA FIS (1..2048)
//   LGMAXDW  payload counter width, 2**LGMAXDW >= MAXDW
//
// Ports
//   i_phy_clk    transmit clock
//   i_reset      synchronous, active-low reset
//   i_link_err   link error, aborts the FIS in flight
//   i_reg_*      register FIS source stream (valid/ready/data/last)
//   i_dat_*      payload source stream (valid/ready/data/last = end of transfer)
//   o_valid, i_ready, o_data, o_last   link-side stream (registered)
//   o_busy       arbiter is not idle
//   o_grant      {dat,reg} owner of the link, 00 when idle
// ---------------------------------------------------------------------------
module satatrn_txarbiter #(
    parameter int MAXDW   = 2048,
    parameter int LGMAXDW = 11
) (
    input  logic        i_phy_clk,
    input  logic        i_reset,
    input  logic        i_link_err,
    input  logic        i_reg_valid,
    output logic        o_reg_ready,
    input  logic [31:0] i_reg_data,
    input  logic        i_reg_last,
    input  logic        i_dat_valid,
    output logic        o_dat_ready,
    input  logic [31:0] i_dat_data,
    input  logic        i_dat_last,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_busy,
    output logic [1:0]  o_grant
);

    localparam logic [31:0]        DATA_HDR = 32'h4600_0000;
    localparam logic [LGMAXDW-1:0] CNT_MAX  = LGMAXDW'(MAXDW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REG  = 2'd1,
        S_DHDR = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic               r_last;
    logic [31:0]        r_data;
    logic [1:0]         r_grant;
    logic [LGMAXDW-1:0] r_cnt;
    logic               r_flush_reg;
    logic               r_flush_dat;
`ifdef TXARB_FAIRNESS_EN
    // 1 = data source won the most recent arbitration.
    logic               r_last_dat;
`endif

    logic w_out_free;
    logic w_reg_take;
    logic w_dat_take;
    logic w_elig_reg;
    logic w_elig_dat;
    logic w_pick_reg;

    assign w_out_free = !r_valid || i_ready;

    // Words actually forwarded to the link (flush discards are not takes).
    assign w_reg_take = (r_state == S_REG)  && w_out_free && i_reg_valid;
    assign w_dat_take = (r_state == S_DATA) && w_out_free && i_dat_valid;

    // A source being flushed must drain its aborted FIS before it can compete.
    assign w_elig_reg = i_reg_valid && !r_flush_reg;
    assign w_elig_dat = i_dat_valid && !r_flush_dat;

`ifdef TXARB_FAIRNESS_EN
    assign w_pick_reg = w_elig_reg && (!w_elig_dat || r_last_dat);
`else
    assign w_pick_reg = w_elig_reg;
`endif

    // A flushing source is never the owner, so the two terms never overlap.
    assign o_reg_ready = r_flush_reg || ((r_state == S_REG)  && w_out_free);
    assign o_dat_ready = r_flush_dat || ((r_state == S_DATA) && w_out_free);

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_grant = r_grant;
    assign o_busy  = (r_state != S_IDLE);

    always_ff @(posedge i_phy_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= 32'h0;
            r_grant     <= 2'b00;
            r_cnt       <= '0;
            r_flush_reg <= 1'b0;
            r_flush_dat <= 1'b0;
`ifdef TXARB_FAIRNESS_EN
            r_last_dat  <= 1'b1;
`endif
        end else begin
            // Flush completes on the discarded last word of the aborted FIS.
            if (r_flush_reg && i_reg_valid && i_reg_last) begin
                r_flush_reg <= 1'b0;
            end
            if (r_flush_dat && i_dat_valid && i_dat_last) begin
                r_flush_dat <= 1'b0;
            end

            if (i_link_err && (r_state != S_IDLE)) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_grant <= 2'b00;
                r_state <= S_IDLE;
                // If the last word is taken in this very cycle the source has
                // finished its FIS and there is nothing left to flush.
                if ((r_state == S_REG) && !(w_reg_take && i_reg_last)) begin
                    r_flush_reg <= 1'b1;
                end
                if ((r_state == S_DHDR) ||
                    ((r_state == S_DATA) && !(w_dat_take && i_dat_last))) begin
                    r_flush_dat <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Arbitrate only once the previous FIS tail has left,
                        // so o_grant always names the owner of the word shown.
                        if (w_out_free) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (w_pick_reg) begin
                                r_state <= S_REG;
                                r_grant <= 2'b01;
`ifdef TXARB_FAIRNESS_EN
                                r_last_dat <= 1'b0;
`endif
                            end else if (w_elig_dat) begin
                                r_state <= S_DHDR;
                                r_grant <= 2'b10;
`ifdef TXARB_FAIRNESS_EN
                                r_last_dat <= 1'b1;
`endif
                            end else begin
                                r_grant <= 2'b00;
                            end
                        end
                    end

                    S_REG: begin
                        if (w_out_free) begin
                            r_valid <= i_reg_valid;
                            if (i_reg_valid) begin
                                r_data <= i_reg_data;
                                r_last <= i_reg_last;
                                if (i_reg_last) begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end

                    S_DHDR: begin
                        if (w_out_free) begin
                            r_valid <= 1'b1;
                            r_data  <= DATA_HDR;
                            r_last  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (w_out_free) begin
                            r_valid <= i_dat_valid;
                            if (i_dat_valid) begin
                                r_data <= i_dat_data;
                                if (i_dat_last) begin
                                    r_last  <= 1'b1;
                                    r_state <= S_IDLE;
                                end else if (r_cnt == CNT_MAX) begin
                                    // FIS full: close it and open the next one
                                    // without giving up the data grant.
                                    r_last  <= 1'b1;
                                    r_state <= S_DHDR;
                                end else begin
                                    r_last <= 1'b0;
                                    r_cnt  <= r_cnt + LGMAXDW'(1);
                                end
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_satatrn_txarbiter.sv
`timescale 1ns/1ps
module tb_satatrn_txarbiter;

    localparam int MAXDW   = 4;
    localparam int LGMAXDW = 2;
`ifdef TXARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset, i_link_err;
    logic        i_reg_valid, o_reg_ready, i_reg_last;
    logic [31:0] i_reg_data;
    logic        i_dat_valid, o_dat_ready, i_dat_last;
    logic [31:0] i_dat_data;
    logic        o_valid, i_ready, o_last, o_busy;
    logic [31:0] o_data;
    logic [1:0]  o_grant;

    always #5 clk = ~clk;

    satatrn_txarbiter #(.MAXDW(MAXDW), .LGMAXDW(LGMAXDW)) dut (
        .i_phy_clk  (clk),
        .i_reset    (i_reset),
        .i_link_err (i_link_err),
        .i_reg_valid(i_reg_valid),
        .o_reg_ready(o_reg_ready),
        .i_reg_data (i_reg_data),
        .i_reg_last (i_reg_last),
        .i_dat_valid(i_dat_valid),
        .o_dat_ready(o_dat_ready),
        .i_dat_data (i_dat_data),
        .i_dat_last (i_dat_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_busy     (o_busy),
        .o_grant    (o_grant)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [1:0]  g;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] reg_words[$];
    logic [31:0] dat_words[$];

    int errors = 0;
    int checks = 0;
    bit reg_done = 1'b1;
    bit dat_done = 1'b1;
    bit abort    = 1'b0;
    int gap_pct  = 0;
    int rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random, 3 never
    bit m_last_dat = 1'b1; // model: data won the previous arbitration

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // ---------------- reference model: expected link words ----------------
    task automatic push_reg();
        for (int i = 0; i < reg_words.size(); i++)
            exp_q.push_back('{d: reg_words[i], l: (i == reg_words.size() - 1), g: 2'b01});
    endtask

    task automatic push_dat();
        int n = dat_words.size();
        for (int i = 0; i < n; i++) begin
            if (i % MAXDW == 0) exp_q.push_back('{d: 32'h4600_0000, l: 1'b0, g: 2'b10});
            exp_q.push_back('{d: dat_words[i], l: (i == n - 1) || (i % MAXDW == MAXDW - 1), g: 2'b10});
        end
    endtask

    // ---------------- source drivers ----------------
    task automatic drive_reg();
        bit hs;
        for (int i = 0; i < reg_words.size() && !abort; i++) begin
            while (i > 0 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct && !abort) begin
                i_reg_valid = 1'b0;
                @(posedge clk); #1;
            end
            i_reg_valid = 1'b1;
            i_reg_data  = reg_words[i];
            i_reg_last  = (i == reg_words.size() - 1);
            hs = 1'b0;
            while (!hs && !abort) begin
                @(negedge clk); hs = o_reg_ready;
                @(posedge clk); #1;
            end
        end
        i_reg_valid = 1'b0;
        i_reg_last  = 1'b0;
        reg_done    = 1'b1;
    endtask

    task automatic drive_dat();
        bit hs;
        for (int i = 0; i < dat_words.size() && !abort; i++) begin
            while (i > 0 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct && !abort) begin
                i_dat_valid = 1'b0;
                @(posedge clk); #1;
            end
            i_dat_valid = 1'b1;
            i_dat_data  = dat_words[i];
            i_dat_last  = (i == dat_words.size() - 1);
            hs = 1'b0;
            while (!hs && !abort) begin
                @(negedge clk); hs = o_dat_ready;
                @(posedge clk); #1;
            end
        end
        i_dat_valid = 1'b0;
        i_dat_last  = 1'b0;
        dat_done    = 1'b1;
    endtask

    // ---------------- link-side ready generator ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ~i_ready;
                2:       i_ready = ($urandom_range(99) < 60);
                default: i_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_stall = 1'b0;
        logic        prev_skip  = 1'b1;
        logic [31:0] prev_d = 32'h0;
        logic        prev_l = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (prev_stall && !prev_skip) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", o_data, prev_d);
                chk("hold_last", 32'(o_last), 32'(prev_l));
            end
            if (o_valid && i_ready && i_reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h required none", o_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn word=%h last=%0d grant=%b", o_data, o_last, o_grant);
                    chk("word_data", o_data, e.d);
                    chk("word_last", 32'(o_last), 32'(e.l));
                    chk("word_grant", 32'(o_grant), 32'(e.g));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_skip  = i_link_err || !i_reset;
            prev_d     = o_data;
            prev_l     = o_last;
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic wait_done(input string name);
        int t = 0;
        while (!(reg_done && dat_done && exp_q.size() == 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words pending required 0", name, exp_q.size());
            abort = 1'b1;
            for (int k = 0; k < 20 && !(reg_done && dat_done); k++) begin
                @(posedge clk); #1;
            end
            exp_q.delete();
            abort = 1'b0;
        end
    endtask

    // kind: 0 reg only, 1 data only, 2 both requesting in the same cycle
    task automatic run_episode(input int kind, input string name);
        bit reg_first;
        @(posedge clk); #1;
        if (kind == 0) begin
            push_reg();
            m_last_dat = 1'b0;
        end else if (kind == 1) begin
            push_dat();
            m_last_dat = 1'b1;
        end else begin
            reg_first = FAIR ? m_last_dat : 1'b1;
            if (reg_first) begin push_reg(); push_dat(); m_last_dat = 1'b1; end
            else           begin push_dat(); push_reg(); m_last_dat = 1'b0; end
        end
        reg_done = (kind == 1);
        dat_done = (kind == 0);
        fork
            if (kind != 1) drive_reg();
            if (kind != 0) drive_dat();
        join_none
        wait_done(name);
        @(negedge clk);
        chk({name, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({name, "_idle_grant"}, 32'(o_grant), 32'd0);
        chk({name, "_idle_valid"}, 32'(o_valid), 32'd0);
    endtask

    task automatic fill_rand(input int nreg, input int ndat);
        reg_words.delete();
        dat_words.delete();
        for (int i = 0; i < nreg; i++) reg_words.push_back($urandom);
        for (int i = 0; i < ndat; i++) dat_words.push_back($urandom);
    endtask

    task automatic link_err_test(input bit with_reg, input string name);
        int cnt = 0;
        int t = 0;
        rdy_mode = 0;
        gap_pct  = 0;
        repeat (2) @(posedge clk);
        #1;
        reg_words.delete();
        dat_words.delete();
        for (int i = 0; i < 10; i++) dat_words.push_back(32'hE000_0000 + 32'(i));
        for (int i = 0; i < 3; i++)  reg_words.push_back(32'hA100_0000 + 32'(i));
        exp_q.push_back('{d: 32'h4600_0000, l: 1'b0, g: 2'b10});
        exp_q.push_back('{d: dat_words[0], l: 1'b0, g: 2'b10});
        exp_q.push_back('{d: dat_words[1], l: 1'b0, g: 2'b10});
        m_last_dat = 1'b1;
        dat_done = 1'b0;
        fork drive_dat(); join_none
        while (cnt < 2 && t < 200) begin
            @(negedge clk);
            if (i_dat_valid && o_dat_ready) cnt++;
            t++;
        end
        chk({name, "_trigger"}, 32'(cnt), 32'd2);
        @(posedge clk); #1 i_link_err = 1'b1;
        @(posedge clk); #1 i_link_err = 1'b0;
        @(negedge clk);
        chk({name, "_valid_drop"}, 32'(o_valid), 32'd0);
        chk({name, "_busy_drop"}, 32'(o_busy), 32'd0);
        chk({name, "_flushing"}, 32'(o_dat_ready), 32'd1);
        if (with_reg) begin
            @(posedge clk); #1;
            push_reg();
            m_last_dat = 1'b0;
            reg_done = 1'b0;
            fork drive_reg(); join_none
        end
        wait_done(name);
        @(negedge clk);
        chk({name, "_flush_clear"}, 32'(o_dat_ready), 32'd0);
    endtask

    // Data transfer stuck in DATA with the link never ready; returns with
    // the data driver stopped and the header held in the output register.
    task automatic stuck_in_data(input string name);
        int t = 0;
        rdy_mode = 3;
        gap_pct  = 0;
        repeat (2) @(posedge clk);
        #1;
        fill_rand(0, 10);
        dat_done = 1'b0;
        fork drive_dat(); join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk({name, "_busy"}, 32'(o_busy), 32'd1);
        chk({name, "_grant"}, 32'(o_grant), 32'd2);
        chk({name, "_valid"}, 32'(o_valid), 32'd1);
        chk({name, "_hdr"}, o_data, 32'h4600_0000);
        abort = 1'b1;
        while (!dat_done && t < 20) begin @(posedge clk); t++; end
        #1 abort = 1'b0;
        m_last_dat = 1'b1;
    endtask

    task automatic pulse_reset_and_check(input string name);
        i_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, 32'(o_valid), 32'd0);
        chk({name, "_data"}, o_data, 32'd0);
        chk({name, "_last"}, 32'(o_last), 32'd0);
        chk({name, "_grant"}, 32'(o_grant), 32'd0);
        chk({name, "_busy"}, 32'(o_busy), 32'd0);
        chk({name, "_dat_ready"}, 32'(o_dat_ready), 32'd0);
        chk({name, "_reg_ready"}, 32'(o_reg_ready), 32'd0);
        @(posedge clk); #1 i_reset = 1'b1;
        m_last_dat = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        i_reset = 1'b0; i_link_err = 1'b0; i_ready = 1'b1;
        i_reg_valid = 1'b0; i_reg_data = 32'h0; i_reg_last = 1'b0;
        i_dat_valid = 1'b0; i_dat_data = 32'h0; i_dat_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_reg_ready", 32'(o_reg_ready), 32'd0);
        chk("rst_dat_ready", 32'(o_dat_ready), 32'd0);
        @(posedge clk); #1 i_reset = 1'b1;

        // register FIS alone
        rdy_mode = 0; gap_pct = 0;
        reg_words = '{32'hA000_0027, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        dat_words.delete();
        run_episode(0, "reg5");

        // six payload dwords split across two DATA FIS
        reg_words.delete();
        dat_words.delete();
        for (int i = 0; i < 6; i++) dat_words.push_back(32'hD000_0000 + 32'(i));
        run_episode(1, "dat6");

        // two ties in a row
        reg_words = '{32'hB000_0027, 32'hB000_0001};
        dat_words = '{32'hC000_0000, 32'hC000_0001};
        run_episode(2, "tie1");
        run_episode(2, "tie2");

        // data under alternating backpressure
        rdy_mode = 1;
        fill_rand(0, 9);
        run_episode(1, "bp_toggle");

        // link errors mid-transfer
        link_err_test(1'b0, "lerr");
        link_err_test(1'b1, "lerr_reg");

        // randomized traffic
        for (int ep = 0; ep < 40; ep++) begin
            rdy_mode = $urandom_range(2);
            gap_pct  = $urandom_range(40);
            fill_rand($urandom_range(1, 6), $urandom_range(1, 11));
            run_episode($urandom_range(2), "rand");
        end

        // reset while in DATA
        stuck_in_data("stuck1");
        pulse_reset_and_check("rst_data");

        // flush pending, flushed source not re-granted, then reset clears flush
        stuck_in_data("stuck2");
        i_link_err = 1'b1;
        @(posedge clk); #1 i_link_err = 1'b0;
        @(negedge clk);
        chk("stuck_err_valid", 32'(o_valid), 32'd0);
        chk("stuck_err_busy", 32'(o_busy), 32'd0);
        chk("stuck_err_flush", 32'(o_dat_ready), 32'd1);
        i_dat_valid = 1'b1; i_dat_last = 1'b0; i_dat_data = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("flush_no_grant", 32'(o_busy), 32'd0);
        i_dat_valid = 1'b0;
        pulse_reset_and_check("rst_flush");

        // traffic after reset, including a tie with the reset-time winner flag
        rdy_mode = 0; gap_pct = 0;
        fill_rand(0, 3);
        run_episode(1, "post_rst");
        reg_words = '{32'hB100_0027, 32'hB100_0001, 32'hB100_0002};
        dat_words = '{32'hC100_0000, 32'hC100_0001, 32'hC100_0002, 32'hC100_0003, 32'hC100_0004};
        run_episode(2, "post_tie");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/satatrn_txarbiter.md
Name: satatrn_txarbiter

Overview:
- Transport-layer transmit arbiter on the PHY clock domain.
- Shares the single link-layer transmit stream between two FIS sources:
  - Register/command FIS source: sends complete FIS, header included.
  - Data source: sends raw payload dwords only.
- For data packets, the block prepends the DATA FIS header (type 8'h46) and splits long payloads into multiple DATA FIS of at most MAXDW payload dwords each.
- Mirrors the RX-side register/data split on transmit.

Parameters:
- MAXDW, 2048: maximum payload dwords per DATA FIS. Legal range 1 to 2048.
- LGMAXDW, 11: width of the payload counter. Must satisfy 2^LGMAXDW >= MAXDW.

Ports:
- i_phy_clk  input  1  transmit clock
- i_reset  input  1  synchronous, active-low reset
- i_link_err  input  1  link error; aborts current FIS
- i_reg_valid  input  1  register source word valid
- o_reg_ready  output  1  register source word accepted
- i_reg_data  input  32  register FIS word; first word carries the FIS type in [31:24]
- i_reg_last  input  1  last word of register FIS
- i_dat_valid  input  1  payload word valid
- o_dat_ready  output  1  payload word accepted
- i_dat_data  input  32  payload dword
- i_dat_last  input  1  last dword of the whole transfer
- o_valid  output  1  link word valid
- i_ready  input  1  link accepts word
- o_data  output  32  link word
- o_last  output  1  last word of FIS
- o_busy  output  1  state is not IDLE
- o_grant  output  2  {dat,reg}; source owning the link, 00 when idle

Behaviour:
- Reset: clock i_phy_clk; reset i_reset, synchronous, active-low. When i_reset==0:
  - State goes to IDLE.
  - o_valid=0, o_last=0, o_data=0, o_grant=0, o_busy=0.
  - Payload counter=0, both flush flags=0.
- Handshake: AXI-stream style; a transfer occurs when valid&&ready.
  - Outputs are registered, one stage.
  - The output register loads when !o_valid || i_ready.
  - Source ready = (state owns that source) && (!o_valid || i_ready).
  - Latency from source handshake to o_valid is 1 cycle.
- State machine:
  - IDLE:
    - If i_reg_valid: grant reg, go to REG (strict register priority).
    - Else if i_dat_valid: go to DHDR.
    - Both pending: reg wins (see the optional feature).
    - Arbitration decision takes one cycle; no source is accepted in IDLE.
  - REG:
    - Pass register words through.
    - On an accepted word with i_reg_last, set o_last=1 and go to IDLE.
  - DHDR:
    - When the output register is free, load o_data=32'h4600_0000, o_last=0, and clear the counter.
    - Go to DATA.
    - No source word is consumed in this state.
  - DATA:
    - Pass payload; the counter increments per accepted dword.
    - If i_dat_last: o_last=1, go to IDLE.
    - Else if counter==MAXDW-1 on accept: o_last=1, go to DHDR. A new FIS starts without re-arbitration; the data grant is kept until i_dat_last.
- Counter width is LGMAXDW bits. With MAXDW=2048 the count never exceeds 2047, so it never wraps.
- Header then i_dat_last on the first payload word: emits a 2-word FIS with o_last on word 2.
- Source deassertion mid-packet holds state; o_valid drops once the register drains.
- i_link_err, higher priority than all transitions except reset:
  - o_valid=0, o_last=0.
  - If the granted source has not delivered its last word, set its flush flag. A flush is pending from DHDR or DATA (data source) or from REG (register source).
  - State goes to IDLE.
  - While a flush flag is set, that source's ready=1 and its words are discarded; the flag clears on its last word. The flushed source is not eligible for grant until then.
  - The other source may be granted meanwhile.
- i_link_err in IDLE with no flush pending: no effect.
- o_busy=1 in REG, DHDR, DATA. Flushing alone does not set o_busy.

Optional Feature:
- Macro TXARB_FAIRNESS_EN.
- Defined:
  - Add a one-bit last-winner flag, reset to dat, so reg wins the first tie.
  - When both sources are valid in IDLE, grant the source that did not win the previous arbitration.
  - A split DATA FIS continuation does not count as a new arbitration.
- Not defined: strict register priority as described above; the flag logic is absent.

Test Plan:
- Reg only, i_ready=1: 5 words A0000027..A0000004, last on word 5.
  - Required: 5 output words identical, o_last on word 5, o_grant=01.
  - Returns to IDLE; o_busy low 1 cycle after the last word.
- Data only, MAXDW=4: 6 payload dwords D0..D5, last on D5.
  - Required output: 46000000,D0,D1,D2,D3(last),46000000,D4,D5(last); total 8 words.
- Both valid in the same cycle, reg 2 words and data 2 dwords.
  - Strict: reg FIS first, then 46000000,D0,D1(last).
  - With TXARB_FAIRNESS_EN, a second identical tie grants data first.
- Backpressure: i_ready toggles 1010... during a data transfer.
  - Required: no dword lost or duplicated; o_data stable while o_valid && !i_ready.
- i_link_err pulsed after 2 payload dwords of a 10-dword transfer.
  - Required: o_valid=0 next cycle; the remaining 8 dwords are consumed with o_valid held low.
  - A reg FIS queued meanwhile goes out intact.
- i_reset low during DATA: all outputs zero the next cycle, state IDLE, flush flags cleared.
